// File: rtl/wb_ram_slave.sv
// Wishbone B4 single-port RAM slave. Handles classic cycles and registered-feedback
// bursts (const/incr), and terminates out-of-range accesses with ERR.
module wb_ram_slave #(
    parameter int unsigned WB_ADDR_WIDTH = 32,
    parameter int unsigned WB_DATA_WIDTH = 32,
    parameter int unsigned DEPTH         = 1024
) (
    input  logic                     WB_CLK_I,
    input  logic                     WB_RST_I,
    input  logic [WB_ADDR_WIDTH-1:0] WB_ADR_I,
    input  logic [WB_DATA_WIDTH-1:0] WB_DAT_I,
    output logic [WB_DATA_WIDTH-1:0] WB_DAT_O,
    input  logic                     WB_WE_I,
    input  logic                     WB_STB_I,
    input  logic                     WB_CYC_I,
    input  logic [2:0]               WB_CTI_I,
    output logic                     WB_ACK_O,
    output logic                     WB_ERR_O,
    output logic                     WB_RTY_O,
    output logic                     WB_STALL_O
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WB_ADDR_WIDTH:0] DEPTH_X = (WB_ADDR_WIDTH+1)'(DEPTH);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLASSIC,
        S_BURST
    } state_t;

    state_t                   state_q, state_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
    logic [WB_ADDR_WIDTH-1:0] baddr_q, baddr_d;

    logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

    logic                     req;
    logic                     adr_ok;
    logic                     accept;
    logic                     commit;
    logic                     rd_en;
    logic [WB_ADDR_WIDTH-1:0] rd_addr;
    logic [WB_ADDR_WIDTH-1:0] nxt;
    logic [AW-1:0]            wr_idx;
    logic [AW-1:0]            rd_idx;

    function automatic logic in_range(input logic [WB_ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_X);
    endfunction

    always_comb begin
        req     = WB_CYC_I & WB_STB_I;
        adr_ok  = in_range(WB_ADR_I);
        accept  = req & (ack_q | err_q);
        commit  = accept & WB_WE_I & adr_ok;
        wr_idx  = WB_ADR_I[AW-1:0];

        state_d = state_q;
        ack_d   = ack_q;
        err_d   = err_q;
        dat_d   = dat_q;
        baddr_d = baddr_q;
        rd_en   = 1'b0;
        rd_addr = WB_ADR_I;
        nxt     = '0;
        rd_idx  = '0;

        case (state_q)
            S_IDLE: begin
                ack_d = 1'b0;
                err_d = 1'b0;
                if (req) begin
                    if (adr_ok) begin
                        ack_d   = 1'b1;
                        rd_en   = 1'b1;
                        rd_addr = WB_ADR_I;
                        baddr_d = WB_ADR_I;
                        state_d = (WB_CTI_I == CTI_CONST || WB_CTI_I == CTI_INCR) ? S_BURST : S_CLASSIC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_CLASSIC;
                    end
                end
            end
            S_CLASSIC: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            S_BURST: begin
                err_d = 1'b0;
                if (!WB_CYC_I) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (accept) begin
                    if (WB_CTI_I == CTI_EOB || WB_CTI_I == CTI_CLASSIC) begin
                        ack_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        nxt     = (WB_CTI_I == CTI_INCR) ? baddr_q + 1'b1 : baddr_q;
                        baddr_d = nxt;
                        if (!in_range(nxt)) begin
                            // Burst ran off the top of memory: no wrap, terminate with ERR.
                            ack_d   = 1'b0;
                            err_d   = 1'b1;
                            state_d = S_CLASSIC;
                        end else begin
                            ack_d   = 1'b1;
                            rd_en   = 1'b1;
                            rd_addr = nxt;
                        end
                    end
                end else if (!WB_STB_I) begin
                    ack_d = 1'b0;
                end else begin
                    ack_d   = 1'b1;
                    rd_en   = 1'b1;
                    rd_addr = baddr_q;
                end
            end
            default: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (rd_en) begin
            rd_idx = rd_addr[AW-1:0];
            // Same-edge write to the prefetched word must be visible in the read data.
            dat_d  = (commit && wr_idx == rd_idx) ? WB_DAT_I : mem[rd_idx];
        end
    end

    always_ff @(posedge WB_CLK_I or posedge WB_RST_I) begin
        if (WB_RST_I) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            baddr_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            baddr_q <= baddr_d;
        end
    end

    always_ff @(posedge WB_CLK_I) begin
        if (commit) begin
            mem[wr_idx] <= WB_DAT_I;
        end
    end

    assign WB_DAT_O   = dat_q;
    assign WB_ACK_O   = ack_q;
    assign WB_ERR_O   = err_q;
    assign WB_RTY_O   = 1'b0;
    assign WB_STALL_O = 1'b0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: classic, incr/const bursts, range errors,
// master wait states and asynchronous reset in the middle of a burst.
module tb_wb_ram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dati;
    logic [31:0] dato;
    logic        we;
    logic        stb;
    logic        cyc;
    logic [2:0]  cti;
    logic        ack;
    logic        err;
    logic        rty;
    logic        stall;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    wb_ram_slave #(
        .WB_ADDR_WIDTH(32),
        .WB_DATA_WIDTH(32),
        .DEPTH(1024)
    ) dut (
        .WB_CLK_I  (clk),
        .WB_RST_I  (rst),
        .WB_ADR_I  (adr),
        .WB_DAT_I  (dati),
        .WB_DAT_O  (dato),
        .WB_WE_I   (we),
        .WB_STB_I  (stb),
        .WB_CYC_I  (cyc),
        .WB_CTI_I  (cti),
        .WB_ACK_O  (ack),
        .WB_ERR_O  (err),
        .WB_RTY_O  (rty),
        .WB_STALL_O(stall)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; adr = '0; dati = '0;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dati = d; cti = c;
    endtask

    // Bus driver only: one classic request held until the accepting edge.
    task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic o_ack, output logic o_err, output logic [31:0] o_dat);
        drive(w, a, d, 3'b000);
        tick;
        o_ack = ack; o_err = err; o_dat = dato;
        tick;
        bus_idle;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus_idle;
        tick; tick;
        n_tests++;
        if ({ack, err, rty, stall} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {ack, err, rty, stall});
        end
        n_tests++;
        if (dato !== 32'h0) begin
            n_fail++; $display("FAIL reset_dat: got %h expected 00000000", dato);
        end
        #4 rst = 1'b0;
        tick;
        n_tests++;
        if ({ack, err} !== 2'b00) begin
            n_fail++; $display("FAIL reset_release: got %b expected 00", {ack, err});
        end
    endtask

    task automatic test_classic;
        drive(1'b1, 32'd3, 32'h3, 3'b000);
        #1;
        n_tests++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL cl_wr_pre: ack got %b expected 0", ack); end
        tick;
        n_tests++;
        if ({ack, err} !== 2'b10) begin n_fail++; $display("FAIL cl_wr_ack: got %b expected 10", {ack, err}); end
        tick;
        bus_idle;
        n_tests++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL cl_wr_pulse: ack got %b expected 0", ack); end
        drive(1'b0, 32'd3, 32'h0, 3'b000);
        tick;
        n_tests++;
        if (ack !== 1'b1 || dato !== 32'h3) begin
            n_fail++; $display("FAIL cl_rd: ack=%b dat=%h expected ack=1 dat=00000003", ack, dato);
        end
        tick;
        bus_idle;
        n_tests++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL cl_rd_pulse: ack got %b expected 0", ack); end
        tick;
        n_tests++;
        if ({ack, err} !== 2'b00) begin n_fail++; $display("FAIL cl_idle: got %b expected 00", {ack, err}); end
    endtask

    task automatic test_burst_incr;
        // write 7..10
        drive(1'b1, 32'd7, 32'd7, 3'b010);
        tick;
        n_tests++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL bw_first: ack got %b expected 1", ack); end
        for (int i = 0; i < 4; i++) begin
            tick;
            n_tests++;
            if (ack !== (i < 3)) begin
                n_fail++; $display("FAIL bw_beat%0d: ack got %b expected %b", i, ack, (i < 3));
            end
            if (i < 3) drive(1'b1, 32'(8 + i), 32'(8 + i), (i == 2) ? 3'b111 : 3'b010);
        end
        bus_idle;
        // read back 7..10
        drive(1'b0, 32'd7, 32'd0, 3'b010);
        tick;
        n_tests++;
        if (ack !== 1'b1 || dato !== 32'd7) begin
            n_fail++; $display("FAIL br_first: ack=%b dat=%h expected ack=1 dat=7", ack, dato);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            if (i < 3) begin
                n_tests++;
                if (ack !== 1'b1 || dato !== 32'(8 + i)) begin
                    n_fail++; $display("FAIL br_beat%0d: ack=%b dat=%h expected ack=1 dat=%h", i, ack, dato, 32'(8 + i));
                end
                drive(1'b0, 32'(8 + i), 32'd0, (i == 2) ? 3'b111 : 3'b010);
            end else begin
                n_tests++;
                if (ack !== 1'b0) begin n_fail++; $display("FAIL br_eob: ack got %b expected 0", ack); end
            end
        end
        bus_idle;
    endtask

    task automatic test_const_fwd;
        logic a, e;
        logic [31:0] q;
        drive(1'b1, 32'd5, 32'hA, 3'b001);
        tick;
        n_tests++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL cf_first: ack got %b expected 1", ack); end
        tick;
        n_tests++;
        if (ack !== 1'b1 || dato !== 32'hA) begin
            n_fail++; $display("FAIL cf_fwd: ack=%b dat=%h expected ack=1 dat=0000000a", ack, dato);
        end
        drive(1'b0, 32'd5, 32'h0, 3'b111);
        tick;
        bus_idle;
        n_tests++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL cf_eob: ack got %b expected 0", ack); end
        tick;
        classic(1'b0, 32'd5, 32'h0, a, e, q);
        n_tests++;
        if (q !== 32'hA) begin n_fail++; $display("FAIL cf_mem: dat got %h expected 0000000a", q); end
    endtask

    task automatic test_range_err;
        logic a, e;
        logic [31:0] q;
        classic(1'b1, 32'd0, 32'h11, a, e, q);
        classic(1'b1, 32'd1022, 32'h3FE, a, e, q);
        classic(1'b1, 32'd1023, 32'h3FF, a, e, q);
        drive(1'b1, 32'd1024, 32'hDEAD, 3'b000);
        tick;
        n_tests++;
        if ({ack, err} !== 2'b01) begin n_fail++; $display("FAIL oor_err: ack,err got %b expected 01", {ack, err}); end
        tick;
        bus_idle;
        n_tests++;
        if ({ack, err} !== 2'b00) begin n_fail++; $display("FAIL oor_pulse: got %b expected 00", {ack, err}); end
        classic(1'b0, 32'd0, 32'h0, a, e, q);
        n_tests++;
        if (q !== 32'h11 || a !== 1'b1) begin
            n_fail++; $display("FAIL oor_nowrite: ack=%b dat=%h expected ack=1 dat=00000011", a, q);
        end
        drive(1'b0, 32'd1022, 32'h0, 3'b010);
        tick;
        n_tests++;
        if ({ack, err} !== 2'b10 || dato !== 32'h3FE) begin
            n_fail++; $display("FAIL top_b0: ack,err=%b dat=%h expected 10 000003fe", {ack, err}, dato);
        end
        tick;
        n_tests++;
        if ({ack, err} !== 2'b10 || dato !== 32'h3FF) begin
            n_fail++; $display("FAIL top_b1: ack,err=%b dat=%h expected 10 000003ff", {ack, err}, dato);
        end
        drive(1'b0, 32'd1023, 32'h0, 3'b010);
        tick;
        n_tests++;
        if ({ack, err} !== 2'b01) begin n_fail++; $display("FAIL top_err: ack,err got %b expected 01", {ack, err}); end
        drive(1'b0, 32'd1024, 32'h0, 3'b010);
        tick;
        bus_idle;
        n_tests++;
        if ({ack, err} !== 2'b00) begin n_fail++; $display("FAIL top_end: got %b expected 00", {ack, err}); end
        tick;
        n_tests++;
        if ({ack, err} !== 2'b00) begin n_fail++; $display("FAIL top_idle: got %b expected 00", {ack, err}); end
    endtask

    task automatic test_wait_state;
        logic a, e;
        logic [31:0] q;
        for (int i = 20; i < 23; i++) classic(1'b1, 32'(i), 32'h100 + 32'(i), a, e, q);
        drive(1'b0, 32'd20, 32'h0, 3'b010);
        tick;
        n_tests++;
        if (ack !== 1'b1 || dato !== 32'h114) begin
            n_fail++; $display("FAIL ws_b0: ack=%b dat=%h expected ack=1 dat=00000114", ack, dato);
        end
        tick;
        stb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            n_tests++;
            if (ack !== 1'b0) begin n_fail++; $display("FAIL ws_wait%0d: ack got %b expected 0", i, ack); end
        end
        drive(1'b0, 32'd21, 32'h0, 3'b010);
        tick;
        n_tests++;
        if (ack !== 1'b1 || dato !== 32'h115) begin
            n_fail++; $display("FAIL ws_resume: ack=%b dat=%h expected ack=1 dat=00000115", ack, dato);
        end
        tick;
        n_tests++;
        if (ack !== 1'b1 || dato !== 32'h116) begin
            n_fail++; $display("FAIL ws_b2: ack=%b dat=%h expected ack=1 dat=00000116", ack, dato);
        end
        drive(1'b0, 32'd22, 32'h0, 3'b111);
        tick;
        bus_idle;
        n_tests++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL ws_eob: ack got %b expected 0", ack); end
    endtask

    task automatic test_reset_mid_burst;
        logic a, e;
        logic [31:0] q;
        drive(1'b1, 32'd30, 32'h30, 3'b010);
        tick;
        tick;
        drive(1'b1, 32'd31, 32'h31, 3'b010);
        tick;
        drive(1'b1, 32'd32, 32'h32, 3'b010);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({ack, err} !== 2'b00 || dato !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid: ack,err=%b dat=%h expected 00 00000000", {ack, err}, dato);
        end
        bus_idle;
        #3 rst = 1'b0;
        tick;
        classic(1'b0, 32'd7, 32'h0, a, e, q);
        n_tests++;
        if (a !== 1'b1 || q !== 32'd7) begin
            n_fail++; $display("FAIL rst_rd7: ack=%b dat=%h expected ack=1 dat=00000007", a, q);
        end
        classic(1'b0, 32'd30, 32'h0, a, e, q);
        n_tests++;
        if (q !== 32'h30) begin n_fail++; $display("FAIL rst_keep30: dat got %h expected 00000030", q); end
        classic(1'b0, 32'd31, 32'h0, a, e, q);
        n_tests++;
        if (q !== 32'h31) begin n_fail++; $display("FAIL rst_keep31: dat got %h expected 00000031", q); end
    endtask

    task automatic test_sweep;
        logic a, e;
        logic [31:0] q;
        for (int i = 0; i < 10; i++) classic(1'b1, 32'(i), 32'hC0DE_0000 | 32'(i * 3), a, e, q);
        for (int i = 0; i < 10; i++) begin
            classic(1'b0, 32'(i), 32'h0, a, e, q);
            n_tests++;
            if (a !== 1'b1 || e !== 1'b0 || q !== (32'hC0DE_0000 | 32'(i * 3))) begin
                n_fail++;
                $display("FAIL sweep%0d: ack=%b err=%b dat=%h expected ack=1 err=0 dat=%h",
                         i, a, e, q, 32'hC0DE_0000 | 32'(i * 3));
            end
        end
    endtask

    initial begin
        test_reset;
        test_classic;
        test_burst_incr;
        test_const_fwd;
        test_range_err;
        test_wait_state;
        test_reset_mid_burst;
        test_sweep;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
